// File: rtl/exe_issue_scheduler.sv
// -----------------------------------------------------------------------------
// exe_issue_scheduler
//
// Issue controller between decode and the variable-latency execute stage.
// ALU results take LAT_DEFAULT cycles and MUL results take LAT_MUL cycles. The
// block tracks every in-flight result in a result-shift register with one slot
// per remaining cycle. It stalls decode on RAW hazards, WAW hazards and
// writeback-port conflicts, so that at most one result completes per cycle and
// results complete in a program-safe order.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   issue_valid_i          decode holds a valid instruction
//   issue_is_mul_i         instruction executes on the MUL unit
//   issue_we_i, issue_rd_i destination write enable / register
//   issue_use_rs1_i/rs1_i  source operand 1 read enable / register
//   issue_use_rs2_i/rs2_i  source operand 2 read enable / register
//   hold_i                 downstream stall, freezes the execute pipeline
//   flush_i                taken branch, squashes everything in execute
//   stall_o                decode must hold its instruction
//   issue_fire_o           instruction accepted this cycle
//   wb_valid_o, wb_rd_o    result completing execute this cycle
//   busy_o                 any result in flight
//   raw_stall_cnt_o        saturating count of RAW/WAW stall cycles
//   struct_stall_cnt_o     saturating count of writeback-port stall cycles
//
// Handshake: decode presents an instruction with issue_valid_i and keeps it
// stable until it is accepted. An instruction is accepted exactly in a cycle
// where issue_fire_o=1; stall_o=1 means "not accepted, present it again".
// -----------------------------------------------------------------------------
module exe_issue_scheduler #(
  parameter int LAT_DEFAULT = 1,
  parameter int LAT_MUL     = 4,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             issue_valid_i,
  input  logic             issue_is_mul_i,
  input  logic             issue_we_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_use_rs1_i,
  input  logic [4:0]       issue_rs1_i,
  input  logic             issue_use_rs2_i,
  input  logic [4:0]       issue_rs2_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             issue_fire_o,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] raw_stall_cnt_o,
  output logic [CNT_W-1:0] struct_stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // One entry per remaining cycle: slot_q[k] completes k cycles from now.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
  } slot_t;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic [DEPTH-1:0] slot_vld;

  logic             eff_we;
  int               lat;
  logic             raw_hz;
  logic             waw_hz;
  logic             struct_hz;
  logic             cnt_en;
  logic             raw_inc;
  logic             struct_inc;

  logic [CNT_W-1:0] raw_cnt_q;
  logic [CNT_W-1:0] struct_cnt_q;

  // x0 is never a real destination: it neither reserves nor matches.
  assign eff_we = issue_we_i && (issue_rd_i != 5'd0);

  // Hazard detection. Slot 0 is writing back in this very cycle, so its value
  // is already visible to an instruction issuing now and it is not a hazard
  // source. A new result lands at slot L-1 >= 0 and so always completes
  // after slot 0, which also rules out a WAW against it.
  always_comb begin
    lat       = issue_is_mul_i ? LAT_MUL : LAT_DEFAULT;
    raw_hz    = 1'b0;
    waw_hz    = 1'b0;
    struct_hz = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if (slot_q[k].valid && slot_q[k].we) begin
        if (issue_use_rs1_i && (issue_rs1_i != 5'd0) && (issue_rs1_i == slot_q[k].rd))
          raw_hz = 1'b1;
        if (issue_use_rs2_i && (issue_rs2_i != 5'd0) && (issue_rs2_i == slot_q[k].rd))
          raw_hz = 1'b1;
        if (eff_we && (issue_rd_i == slot_q[k].rd))
          waw_hz = 1'b1;
      end
      // slot[L] shifts into slot[L-1] next cycle, the position the new
      // result would take. L = DEPTH has no slot[L] and never conflicts.
      if ((k == lat) && slot_q[k].valid)
        struct_hz = 1'b1;
    end
  end

  assign stall_o = issue_valid_i && (hold_i || raw_hz || waw_hz || struct_hz);

  // Nothing is accepted while reset is asserted: the slots are held cleared.
  assign issue_fire_o = rstn_i && issue_valid_i && !stall_o && !flush_i;

  // Next-state of the result-shift register. Flush beats hold; a held
  // pipeline neither shifts nor accepts.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_d[k] = '0;
      end
    end else if (!hold_i) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slot_d[k] = slot_q[k + 1];
      end
      slot_d[DEPTH-1] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (issue_fire_o && (k == lat - 1))
          slot_d[k] = {1'b1, eff_we, (eff_we ? issue_rd_i : 5'd0)};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // Stall accounting. Each stalled cycle is counted once: RAW/WAW wins over
  // a simultaneous port conflict. Cycles frozen by hold or squashed by flush
  // are not attributed to this block.
  assign cnt_en     = !flush_i && !hold_i;
  assign raw_inc    = cnt_en && issue_valid_i && (raw_hz || waw_hz);
  assign struct_inc = cnt_en && issue_valid_i && struct_hz && !(raw_hz || waw_hz);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      raw_cnt_q    <= '0;
      struct_cnt_q <= '0;
    end else begin
      if (raw_inc && (raw_cnt_q != '1))
        raw_cnt_q <= raw_cnt_q + CNT_ONE;
      if (struct_inc && (struct_cnt_q != '1))
        struct_cnt_q <= struct_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_vld[k] = slot_q[k].valid;
    end
  end

  assign wb_valid_o         = slot_q[0].valid;
  assign wb_rd_o            = slot_q[0].we ? slot_q[0].rd : 5'd0;
  assign busy_o             = |slot_vld;
  assign raw_stall_cnt_o    = raw_cnt_q;
  assign struct_stall_cnt_o = struct_cnt_q;

endmodule
